// File: rtl/wb_trace_buffer.sv
// Passive trace collector: captures register writebacks and data-memory stores as
// cycle-stamped records into a first-word-fall-through FIFO drained over valid/ready.
module wb_trace_buffer #(
  parameter int DEPTH      = 16,
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     reg_write_sig,
  input  logic [4:0]               reg_num,
  input  logic [DATA_W-1:0]        reg_data,
  input  logic                     wr,
  input  logic [DM_ADDRESS-1:0]    addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     out_ready,
  input  logic                     clr_overflow,
  output logic                     out_valid,
  output logic [CNT_W-1:0]         out_cycle,
  output logic                     out_rf_valid,
  output logic [4:0]               out_rd,
  output logic [DATA_W-1:0]        out_rd_data,
  output logic                     out_st_valid,
  output logic [DM_ADDRESS-1:0]    out_st_addr,
  output logic [DATA_W-1:0]        out_st_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  typedef struct packed {
    logic [CNT_W-1:0]      cycle;
    logic                  rf_v;
    logic [4:0]            rd;
    logic [DATA_W-1:0]     rd_data;
    logic                  st_v;
    logic [DM_ADDRESS-1:0] st_addr;
    logic [DATA_W-1:0]     st_data;
  } rec_t;

  rec_t            mem_q [DEPTH];
  rec_t            head_q, head_d, new_rec;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic [CNT_W-1:0] cyc_q;
  logic            overflow_q, overflow_d;
  logic [15:0]     drop_q, drop_d;
  logic            rf_ev, push_req, pop, full, push, drop;

  always_comb begin
    rf_ev    = reg_write_sig && (reg_num != 5'd0);
    push_req = en && (rf_ev || wr);
    pop      = (count_q != '0) && out_ready;
    full     = (count_q == FULL_CNT);
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;

    new_rec.cycle   = cyc_q;
    new_rec.rf_v    = rf_ev;
    new_rec.rd      = rf_ev ? reg_num : 5'd0;
    new_rec.rd_data = rf_ev ? reg_data : '0;
    new_rec.st_v    = wr;
    new_rec.st_addr = wr ? addr : '0;
    new_rec.st_data = wr ? wr_data : '0;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    // The registered head tracks the record that will sit at rd_ptr after this edge;
    // it may be the one being written right now, which is not yet in storage.
    head_d = head_q;
    if (count_d != '0)
      head_d = (push && (wr_ptr_q == rd_ptr_d)) ? new_rec : mem_q[rd_ptr_d];

    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_overflow)            drop_d = 16'd1;
      else if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
      drop_d     = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_rec;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cyc_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      head_q     <= head_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cyc_q      <= cyc_q + 1'b1;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  assign out_valid    = (count_q != '0);
  assign out_cycle    = head_q.cycle;
  assign out_rf_valid = head_q.rf_v;
  assign out_rd       = head_q.rd;
  assign out_rd_data  = head_q.rd_data;
  assign out_st_valid = head_q.st_v;
  assign out_st_addr  = head_q.st_addr;
  assign out_st_data  = head_q.st_data;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer with a queue scoreboard of expected trace records.
module tb_wb_trace_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, reg_write_sig, wr, out_ready, clr_overflow;
  logic [4:0]  reg_num;
  logic [31:0] reg_data, wr_data;
  logic [8:0]  addr;
  logic        out_valid, out_rf_valid, out_st_valid, overflow;
  logic [31:0] out_cycle, out_rd_data, out_st_data;
  logic [4:0]  out_rd;
  logic [8:0]  out_st_addr;
  logic [4:0]  count;
  logic [15:0] drop_count;

  typedef struct {
    logic [31:0] cyc;
    logic        rfv;
    logic [4:0]  rd;
    logic [31:0] rdd;
    logic        stv;
    logic [8:0]  sa;
    logic [31:0] sd;
  } rec_t;

  rec_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned mCyc = 0;
  int unsigned mDc = 0;
  logic        mOv = 1'b0;

  wb_trace_buffer #(.DEPTH(DEPTH), .DATA_W(32), .DM_ADDRESS(9), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .en(en), .reg_write_sig(reg_write_sig), .reg_num(reg_num),
    .reg_data(reg_data), .wr(wr), .addr(addr), .wr_data(wr_data), .out_ready(out_ready),
    .clr_overflow(clr_overflow), .out_valid(out_valid), .out_cycle(out_cycle),
    .out_rf_valid(out_rf_valid), .out_rd(out_rd), .out_rd_data(out_rd_data),
    .out_st_valid(out_st_valid), .out_st_addr(out_st_addr), .out_st_data(out_st_data),
    .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rfw, input logic [4:0] rn, input logic [31:0] rdat,
                               input logic w, input logic [8:0] a, input logic [31:0] wd);
    reg_write_sig = rfw; reg_num = rn; reg_data = rdat;
    wr = w; addr = a; wr_data = wd;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 9'd0, 32'd0);
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, "_count"}, 64'(count), 64'(sb.size()));
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'(sb.size() != 0));
    checkOutput({tag, "_overflow"}, 64'(overflow), 64'(mOv));
    checkOutput({tag, "_drops"}, 64'(drop_count), 64'(mDc));
  endtask

  task automatic checkHead(input string tag);
    checkOutput({tag, "_cycle"}, 64'(out_cycle), 64'(sb[0].cyc));
    checkOutput({tag, "_rfv"}, 64'(out_rf_valid), 64'(sb[0].rfv));
    checkOutput({tag, "_rd"}, 64'(out_rd), 64'(sb[0].rd));
    checkOutput({tag, "_rdd"}, 64'(out_rd_data), 64'(sb[0].rdd));
    checkOutput({tag, "_stv"}, 64'(out_st_valid), 64'(sb[0].stv));
    checkOutput({tag, "_sa"}, 64'(out_st_addr), 64'(sb[0].sa));
    checkOutput({tag, "_sd"}, 64'(out_st_data), 64'(sb[0].sd));
  endtask

  // One clock: predict the edge from the currently driven inputs, then advance.
  task automatic stepCycle();
    logic rfe, pr, pop;
    rec_t r;
    rfe = reg_write_sig && (reg_num != 5'd0);
    pr  = en && (rfe || wr);
    pop = (sb.size() != 0) && out_ready;
    checkOutput("step_valid", 64'(out_valid), 64'(sb.size() != 0));
    if (pop) begin
      checkHead("pop");
      void'(sb.pop_front());
    end
    if (pr && sb.size() < DEPTH) begin
      r.cyc = mCyc; r.rfv = rfe; r.rd = rfe ? reg_num : 5'd0; r.rdd = rfe ? reg_data : 32'd0;
      r.stv = wr; r.sa = wr ? addr : 9'd0; r.sd = wr ? wr_data : 32'd0;
      sb.push_back(r);
    end else if (pr) begin
      mOv = 1'b1;
      if (clr_overflow) mDc = 1;
      else if (mDc != 16'hFFFF) mDc++;
    end else if (clr_overflow) begin
      mOv = 1'b0;
      mDc = 0;
    end
    @(posedge clk);
    mCyc++;
    #1;
  endtask

  task automatic pushRandom(input int i);
    applyStimulus(1'b1, 5'((i % 31) + 1), $urandom, 1'(i % 2), 9'($urandom), $urandom);
  endtask

  initial begin
    logic [31:0] s0;
    logic [31:0] snapCyc, snapRdd, snapSd;
    reset = 1'b0; en = 1'b1; out_ready = 1'b0; clr_overflow = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    mCyc = 0;
    checkStatus("reset");
    checkOutput("reset_cycle", 64'(out_cycle), 64'd0);
    checkOutput("reset_rdd", 64'(out_rd_data), 64'd0);
    checkOutput("reset_sd", 64'(out_st_data), 64'd0);

    repeat (5) stepCycle();
    checkStatus("idle5");
    repeat (2) stepCycle();

    out_ready = 1'b1;
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 9'd0, 32'd0);
    stepCycle();
    idle();
    checkOutput("wb_valid", 64'(out_valid), 64'd1);
    checkOutput("wb_cycle", 64'(out_cycle), 64'd7);
    checkOutput("wb_rd", 64'(out_rd), 64'd5);
    checkOutput("wb_rdd", 64'(out_rd_data), 64'hDEADBEEF);
    checkOutput("wb_stv", 64'(out_st_valid), 64'd0);
    stepCycle();
    stepCycle();

    applyStimulus(1'b1, 5'd0, 32'hCAFEF00D, 1'b1, 9'h010, 32'h12345678);
    stepCycle();
    idle();
    checkOutput("st_rfv", 64'(out_rf_valid), 64'd0);
    checkOutput("st_rd", 64'(out_rd), 64'd0);
    checkOutput("st_rdd", 64'(out_rd_data), 64'd0);
    checkOutput("st_stv", 64'(out_st_valid), 64'd1);
    checkOutput("st_sa", 64'(out_st_addr), 64'h010);
    checkOutput("st_sd", 64'(out_st_data), 64'h12345678);
    stepCycle();
    stepCycle();

    out_ready = 1'b0;
    s0 = mCyc;
    for (int i = 0; i < 18; i++) begin
      pushRandom(i);
      stepCycle();
    end
    idle();
    checkStatus("overflow");
    checkOutput("ovf_count", 64'(count), 64'd16);
    checkOutput("ovf_flag", 64'(overflow), 64'd1);
    checkOutput("ovf_drops", 64'(drop_count), 64'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checkOutput("drain_stamp", 64'(out_cycle), 64'(s0 + 32'(k)));
      stepCycle();
    end
    stepCycle();
    checkStatus("drained");

    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pushRandom(i + 3);
      stepCycle();
    end
    out_ready = 1'b1;
    pushRandom(40);
    stepCycle();
    idle();
    out_ready = 1'b0;
    checkOutput("pp_count", 64'(count), 64'd16);
    checkOutput("pp_drops", 64'(drop_count), 64'd2);
    clr_overflow = 1'b1;
    stepCycle();
    clr_overflow = 1'b0;
    checkOutput("clr_flag", 64'(overflow), 64'd0);
    checkOutput("clr_drops", 64'(drop_count), 64'd0);
    pushRandom(7);
    clr_overflow = 1'b1;
    stepCycle();
    clr_overflow = 1'b0;
    checkOutput("clrdrop_flag", 64'(overflow), 64'd1);
    checkOutput("clrdrop_drops", 64'(drop_count), 64'd1);
    en = 1'b0;
    pushRandom(9);
    stepCycle();
    checkStatus("en_off");
    out_ready = 1'b1;
    repeat (17) stepCycle();
    checkStatus("en_off_drain");

    en = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pushRandom(i + 11);
      stepCycle();
    end
    idle();
    snapCyc = out_cycle; snapRdd = out_rd_data; snapSd = out_st_data;
    repeat (2) stepCycle();
    checkHead("hold");
    checkOutput("hold_cycle", 64'(out_cycle), 64'(snapCyc));
    checkOutput("hold_rdd", 64'(out_rd_data), 64'(snapRdd));
    checkOutput("hold_sd", 64'(out_st_data), 64'(snapSd));
    reset = 1'b0;
    #1;
    sb.delete();
    mOv = 1'b0; mDc = 0;
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_count", 64'(count), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    mCyc = 0;
    applyStimulus(1'b1, 5'd31, 32'hA5A5A5A5, 1'b0, 9'd0, 32'd0);
    stepCycle();
    idle();
    checkOutput("rst_stamp", 64'(out_cycle), 64'd0);
    out_ready = 1'b1;
    stepCycle();
    stepCycle();
    checkStatus("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Passive trace collector on the pipeline's debug outputs: register-file writeback (reg_num/reg_data/reg_write_sig) and data-memory store (wr/addr/wr_data).
- Each cycle with a qualifying event is captured as one cycle-stamped record into a FIFO.
- The FIFO drains through a valid/ready stream to a bench scoreboard or debug UART.
- Sits beside the core at top level and never back-pressures the pipeline; records that do not fit are dropped and counted.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
DATA_W, 32, register/store data width
DM_ADDRESS, 9, data-memory address width
CNT_W, 32, cycle-stamp counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
en  in  1  capture enable
reg_write_sig  in  1  writeback write strobe
reg_num  in  5  writeback destination register
reg_data  in  DATA_W  writeback data
wr  in  1  data-memory write strobe
addr  in  DM_ADDRESS  data-memory address
wr_data  in  DATA_W  data-memory write data
out_ready  in  1  sink ready
clr_overflow  in  1  clears overflow and drop_count
out_valid  out  1  head record valid
out_cycle  out  CNT_W  cycle stamp of head record
out_rf_valid  out  1  head record contains a register write
out_rd  out  5  register number
out_rd_data  out  DATA_W  register data
out_st_valid  out  1  head record contains a store
out_st_addr  out  DM_ADDRESS  store address
out_st_data  out  DATA_W  store data
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky drop flag
drop_count  out  16  dropped records, saturating

Behaviour:
- Reset (reset==0, async):
  - FIFO emptied; read/write pointers and count = 0.
  - cycle counter, overflow and drop_count = 0.
  - out_valid = 0; all out_* data fields = 0.
  - Reset asserted mid-operation discards all stored records immediately.
- Cycle counter:
  - Holds 0 during the first rising edge after reset release, then increments every clock, independent of en.
  - Wraps modulo 2^CNT_W.
- Event qualification (combinational):
  - rf_ev = reg_write_sig && reg_num != 0; writes to x0 are ignored.
  - st_ev = wr.
  - push_req = en && (rf_ev || st_ev).
- Record contents:
  - {cycle, rf_ev, reg_num, reg_data, st_ev, addr, wr_data}, sampled at the capturing edge.
  - Fields of a non-valid half are stored as 0.
  - Simultaneous WB and store form ONE record with both valid bits set.
- FIFO:
  - First-word-fall-through; head record drives out_* directly from storage or a registered head.
  - Latency: record pushed at edge N into an empty FIFO gives out_valid=1 after edge N; it is visible in cycle N+1.
  - pop = out_valid && out_ready; the head advances at the edge.
  - While out_valid && !out_ready, all out_* are stable.
  - When empty, out_valid = 0 and data fields hold their last value.
  - Pointers wrap modulo DEPTH.
  - count: +1 on push only, -1 on pop only, unchanged on both or neither; range 0..DEPTH.
- Full handling:
  - push_req with count==DEPTH and no pop in the same cycle: record dropped, overflow <= 1, drop_count +1 (saturates at 16'hFFFF).
  - push_req with count==DEPTH and a pop in the same cycle: push accepted, count stays DEPTH, no drop.
  - Push into an empty FIFO with out_ready=1: no same-cycle bypass; the record appears the next cycle.
- clr_overflow:
  - Clears overflow and drop_count at the edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- en=0: no captures and no drops counted; draining continues normally.

Test Plan:
- Reset then idle 5 cycles with reg_write_sig=0, wr=0 -> out_valid=0, count=0, overflow=0, drop_count=0.
- At counter=7: reg_write_sig=1, reg_num=5, reg_data=32'hDEADBEEF; out_ready=1 -> next cycle out_valid=1, out_cycle=7, out_rf_valid=1, out_rd=5, out_rd_data=DEADBEEF, out_st_valid=0; then out_valid=0.
- Same cycle: reg_num=0 write plus wr=1, addr=9'h010, wr_data=32'h12345678 -> single record with out_rf_valid=0, out_rd=0, out_st_valid=1, out_st_addr=010, out_st_data=12345678.
- out_ready=0; push 18 consecutive events (DEPTH=16) -> count=16, overflow=1, drop_count=2; then drain with out_ready=1 -> 16 records in order with consecutive out_cycle stamps.
- FIFO full, push and pop in the same cycle -> count stays 16, drop_count unchanged; clr_overflow pulse with no drop -> overflow=0, drop_count=0.
- With 3 records stored, hold out_ready=0 (out_* stable), assert reset=0 for 1 cycle -> out_valid=0 and count=0 immediately; the next event's stamp is relative to the new counter start.
